// File: rtl/semafor_pkg.sv
// Shared constants for the pedestrian-slot arbiter and the crossing controllers:
// FSM state encoding and default timing.
package semafor_pkg;

  localparam logic [0:0] ST_GAP   = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  localparam int N_CROSS_DEF      = 4;
  localparam int GAP_CYCLES_DEF   = 60;
  localparam int DONE_TIMEOUT_DEF = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/semafor_arbiter_if.sv
// Crossing-side bundle of the arbiter: buttons and done pulses in,
// grant / pending lamps / status out.
interface semafor_arbiter_if #(
  parameter int N_CROSS = 4
) ();

  logic [N_CROSS-1:0] btn;
  logic [N_CROSS-1:0] done;
  logic [N_CROSS-1:0] grant;
  logic [N_CROSS-1:0] pend;
  logic               busy;
  logic               timeout_err;

  modport master (
    output btn, done,
    input  grant, pend, busy, timeout_err
  );

  modport slave (
    input  btn, done,
    output grant, pend, busy, timeout_err
  );

endinterface

// File: rtl/semafor_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo N.
module semafor_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     onehot_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] cand_idx [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr_i} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                   : sum[IDX_W-1:0];
    end
  endgenerate

  // Walk from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    onehot_o = '0;
    valid_o  = 1'b0;
    idx_o    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[cand_idx[k]]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx[k];
      end
    end
    if (valid_o) onehot_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/semafor_arbiter.sv
// Round-robin owner of the shared pedestrian phase slot with a car-green gap
// and done timeout. Define SEMAFOR_ARB_PRIO_EN to give crossing 0 fixed priority.
module semafor_arbiter
  import semafor_pkg::*;
#(
  parameter int N_CROSS      = N_CROSS_DEF,
  parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  semafor_arbiter_if.slave  arb_if
);

  localparam int IDX_W = (N_CROSS > 1) ? $clog2(N_CROSS) : 1;
  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, DONE_TIMEOUT));
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(DONE_TIMEOUT - 1);

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_CROSS-1:0] btn_q;
  logic [N_CROSS-1:0] pend_q, pend_d;
  logic [N_CROSS-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;

  logic [N_CROSS-1:0] btn_rise;
  logic               done_hit;
  logic [N_CROSS-1:0] rr_onehot;
  logic               rr_valid;
  logic [IDX_W-1:0]   rr_idx;
  logic [N_CROSS-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   ptr_after_win;

  assign btn_rise = arb_if.btn & ~btn_q;
  assign done_hit = |(arb_if.done & grant_q);

  semafor_rr_pick #(
    .N     (N_CROSS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (pend_q),
    .ptr_i    (ptr_q),
    .onehot_o (rr_onehot),
    .valid_o  (rr_valid),
    .idx_o    (rr_idx)
  );

`ifdef SEMAFOR_ARB_PRIO_EN
  // School crossing 0 overrides the rotation whenever it is waiting.
  always_comb begin
    win_onehot = rr_onehot;
    win_idx    = rr_idx;
    if (pend_q[0]) begin
      win_onehot    = '0;
      win_onehot[0] = 1'b1;
      win_idx       = '0;
    end
  end
`else
  assign win_onehot = rr_onehot;
  assign win_idx    = rr_idx;
`endif

  assign ptr_after_win = (win_idx == IDX_W'(N_CROSS - 1)) ? '0 : win_idx + IDX_W'(1);

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    terr_d    = terr_q;
    pend_d    = pend_q | (btn_rise & ~grant_q);

    case (state_q)
      ST_GAP: begin
        if (gap_cnt_q != GAP_LAST) begin
          gap_cnt_d = gap_cnt_q + CNT_W'(1);
        end else if (rr_valid) begin
          // Clearing the winner after the OR makes a same-edge press lose.
          grant_d  = win_onehot;
          pend_d   = pend_d & ~win_onehot;
          ptr_d    = ptr_after_win;
          to_cnt_d = '0;
          state_d  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (done_hit) begin
          grant_d   = '0;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else if (to_cnt_q == TO_LAST) begin
          grant_d   = '0;
          terr_d    = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_GAP;
    endcase

    busy_d = (state_d == ST_SERVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_GAP;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
      ptr_q     <= '0;
      btn_q     <= '0;
      pend_q    <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
      ptr_q     <= ptr_d;
      btn_q     <= arb_if.btn;
      pend_q    <= pend_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
    end
  end

  assign arb_if.grant       = grant_q;
  assign arb_if.pend        = pend_q;
  assign arb_if.busy        = busy_q;
  assign arb_if.timeout_err = terr_q;

endmodule

// File: doc/semafor_arbiter.md
# semafor_arbiter

Round-robin scheduler that shares the single pedestrian-phase slot of a road segment between up to eight pedestrian crossings. Latches button presses from each crossing, enforces a minimum car-green gap between pedestrian phases, and issues a one-hot grant to exactly one crossing controller at a time. It sits above the per-crossing traffic-light controllers: grant starts their yellow→red/pedestrian-green sequence, and their `done` pulse returns the slot.

## Interface
- `N_CROSS`, 4: number of crossings, legal 1..8.
- `GAP_CYCLES`, 60: minimum car-green cycles between grants, ≥1.
- `DONE_TIMEOUT`, 64: max cycles a grant may be held without `done`, ≥2.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `btn`  in  N_CROSS  pedestrian buttons, synchronous level; one bit per crossing.
- `done`  in  N_CROSS  one-cycle pulse from crossing i: pedestrian phase finished.
- `grant`  out  N_CROSS  one-hot or zero; crossing i may run its pedestrian phase.
- `pend`  out  N_CROSS  latched pending requests, drives "wait" lamps.
- `busy`  out  1  high while a grant is held.
- `timeout_err`  out  1  sticky; a grant was revoked by timeout.

## Operation
- Reset values: `grant`=0, `pend`=0, `busy`=0, `timeout_err`=0, state GAP, gap counter 0, RR pointer 0, `btn` history 0.
- Request capture: `pend[i]` sets on rising edge of `btn[i]` (btn & ~btn_q). Press while `grant[i]`=1 is ignored. Press on the same edge that grants i: clear wins.
- States: GAP, SERVE.
- GAP: gap counter increments, saturating at GAP_CYCLES-1. When counter = GAP_CYCLES-1 and `pend`≠0: pick winner, `grant` ← onehot(winner), `pend[winner]` ← 0, pointer ← (winner+1) mod N_CROSS, timeout counter ← 0, → SERVE. No pend: remain in GAP, counter saturated.
- Winner: first set `pend` bit searching upward from pointer, wrapping.
- SERVE: `grant` held; timeout counter increments. `done[w]` for granted w → `grant` ← 0, gap counter ← 0, → GAP. `done` bits of non-granted crossings ignored.
- Timeout: timeout counter = DONE_TIMEOUT-1 without `done[w]` → `grant` ← 0, `timeout_err` ← 1, gap counter ← 0, → GAP. `done[w]` on same cycle: done wins, no error.
- `busy` registered, equals (state = SERVE).
- `timeout_err` cleared only by reset.
- Counters: width $clog2(max(GAP_CYCLES, DONE_TIMEOUT)) bits, never wrap.

## Timing
- `btn` edge → `pend` visible next edge (1 cycle).
- Gap elapsed with pend → `grant` rises on next edge; after reset first grant no earlier than edge GAP_CYCLES.
- `done[w]` → `grant` falls next edge; next grant rises exactly GAP_CYCLES edges after fall if pend≠0.
- Grant held at most DONE_TIMEOUT cycles.
- `rst_n` low mid-SERVE: all outputs to reset values immediately (async), pending requests lost.

## Configuration
- `SEMAFOR_ARB_PRIO_EN` defined: crossing 0 is fixed-priority (school crossing); if `pend[0]`=1 at grant decision, 0 wins regardless of pointer; pointer still updates to 1.
- Undefined: pure round-robin for all crossings.

## Structure
- Shared package `semafor_pkg`: state encoding localparams (GAP, SERVE), default timing constants (GAP_CYCLES, DONE_TIMEOUT) shared with crossing controllers.
- One sub-module: `semafor_rr_pick` — combinational N_CROSS-wide round-robin picker (req, pointer → onehot, valid, index).

## Test plan
- N_CROSS=4, GAP_CYCLES=8, DONE_TIMEOUT=16 unless stated.
- Reset release, `btn[2]` pulse at cycle 2 → `pend`=0100 at cycle 3; `grant`=0100, `pend`=0000, `busy`=1 at edge 8.
- `pend`=1011 with pointer 0, `done` returned 3 cycles after each grant → grants 0001, 0010, 1000 in order, rising edges 8 apart after each fall.
- `grant`=0010, no `done` → `grant`=0 after 16 cycles, `timeout_err`=1, stays 1 through later normal grants until reset.
- `done[3]` pulse while `grant`=0010 → ignored; `done[1]` same cycle as timeout → no error.
- `btn[1]` press during grant 0010 → `pend[1]` stays 0; press during GAP → latched and served next.
- SEMAFOR_ARB_PRIO_EN, pointer 3, `pend`=1001 → `grant`=0001 first; `rst_n` low during SERVE → `grant`=0 asynchronously.
